// File: rtl/fetch_burst_master.sv
// fetch_burst_master: instruction-fetch burst initiator with an in-order instruction FIFO.
//   Issues BURST_ACC-sized read bursts from the fetch PC whenever the FIFO can hold
//   the whole burst. Buffered words are presented to decode with their PC via a
//   valid/ready handshake. A redirect aborts any burst, flushes the FIFO and reloads the PC.
// Ports:
//   clk, rst_n (async, active low)
//   redirect, redirect_pc          : branch redirect (low two PC bits forced to 0)
//   mem_addr, mem_en, mem_wren,
//   mem_acc_size, mem_d_out,
//   mem_busy                       : main-memory burst read interface
//   inst_valid, inst_ready,
//   inst_data, inst_pc             : FIFO head to decode
//   fifo_count                     : FIFO occupancy, 0..FIFO_DEPTH
// Optional build macro FETCH_PERF_CNT_EN adds perf_bursts, perf_stall, busy_err.
module fetch_burst_master #(
  parameter int unsigned             ADDRESS_SIZE  = 32,
  parameter int unsigned             DATA_SIZE     = 32,
  parameter int unsigned             FIFO_DEPTH    = 16,
  parameter logic [1:0]              BURST_ACC     = 2'b01,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h8002_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          redirect,
  input  logic [ADDRESS_SIZE-1:0]       redirect_pc,
  output logic [ADDRESS_SIZE-1:0]       mem_addr,
  output logic                          mem_en,
  output logic                          mem_wren,
  output logic [1:0]                    mem_acc_size,
  input  logic [DATA_SIZE-1:0]          mem_d_out,
  input  logic                          mem_busy,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [DATA_SIZE-1:0]          inst_data,
  output logic [ADDRESS_SIZE-1:0]       inst_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_bursts,
  output logic [31:0]                   perf_stall,
  output logic                          busy_err
`endif
);

  localparam int unsigned BURST_LEN = (BURST_ACC == 2'b00) ? 1 :
                                      (BURST_ACC == 2'b01) ? 4 :
                                      (BURST_ACC == 2'b10) ? 8 : 16;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]        SPACE_LIMIT = CNT_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [3:0]              LAST_CAP    = 4'(BURST_LEN - 1);
  localparam logic [ADDRESS_SIZE-1:0] BURST_BYTES = ADDRESS_SIZE'(4 * BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDRESS_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic                      mem_en_q, mem_en_d;
  logic [3:0]                cap_cnt_q, cap_cnt_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DATA_SIZE-1:0]      data_q [FIFO_DEPTH];
  logic [DATA_SIZE-1:0]      data_d [FIFO_DEPTH];
  logic [ADDRESS_SIZE-1:0]   pc_q   [FIFO_DEPTH];
  logic [ADDRESS_SIZE-1:0]   pc_d   [FIFO_DEPTH];

  logic push, pop, launch, space_ok;
  logic [1:0] unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[1:0];
  assign space_ok      = (count_q <= SPACE_LIMIT);

  assign mem_addr     = mem_addr_q;
  assign mem_en       = mem_en_q;
  assign mem_wren     = 1'b0;
  assign mem_acc_size = BURST_ACC;
  assign inst_valid   = (count_q != '0);
  assign inst_data    = data_q[rd_ptr_q];
  assign inst_pc      = pc_q[rd_ptr_q];
  assign fifo_count   = count_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    mem_en_d   = mem_en_q;
    cap_cnt_d  = cap_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    pc_d       = pc_q;
    push       = 1'b0;
    launch     = 1'b0;
    pop        = inst_valid && inst_ready && !redirect;

    case (state_q)
      ST_IDLE: begin
        if (!redirect && space_ok) begin
          launch     = 1'b1;
          mem_addr_d = fetch_pc_q;
          mem_en_d   = 1'b1;
          cap_cnt_d  = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        // Every BURST edge captures the word presented after the previous edge.
        push      = 1'b1;
        cap_cnt_d = cap_cnt_q + 4'd1;
        if (cap_cnt_q == LAST_CAP) begin
          fetch_pc_d = fetch_pc_q + BURST_BYTES;
          mem_en_d   = 1'b0;
          state_d    = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      data_d[wr_ptr_q] = mem_d_out;
      pc_d[wr_ptr_q]   = mem_addr_q + ADDRESS_SIZE'({cap_cnt_q, 2'b00});
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    // Redirect overrides everything above; any data written this edge is orphaned.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[ADDRESS_SIZE-1:2], 2'b00};
      mem_en_d   = 1'b0;
      state_d    = ST_GAP;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= START_ADDRESS;
      mem_addr_q <= START_ADDRESS;
      mem_en_q   <= 1'b0;
      cap_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_en_q   <= mem_en_d;
      cap_cnt_q  <= cap_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bursts_q, perf_bursts_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        busy_err_q, busy_err_d;

  always_comb begin
    perf_bursts_d = perf_bursts_q;
    perf_stall_d  = perf_stall_q;
    busy_err_d    = busy_err_q;
    if (launch) begin
      perf_bursts_d = perf_bursts_q + 32'd1;
    end
    if (state_q == ST_IDLE && !mem_en_q && !space_ok) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (state_q == ST_BURST && !mem_busy && cap_cnt_q < LAST_CAP) begin
      busy_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bursts_q <= '0;
      perf_stall_q  <= '0;
      busy_err_q    <= 1'b0;
    end else begin
      perf_bursts_q <= perf_bursts_d;
      perf_stall_q  <= perf_stall_d;
      busy_err_q    <= busy_err_d;
    end
  end

  assign perf_bursts = perf_bursts_q;
  assign perf_stall  = perf_stall_q;
  assign busy_err    = busy_err_q;
`else
  logic unused_mem_busy;
  assign unused_mem_busy = mem_busy;
`endif

endmodule

// File: tb/tb_fetch_burst_master.sv
module tb_fetch_burst_master;

  localparam logic [31:0] START = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic        mem_wren;
  logic [1:0]  mem_acc_size;
  logic [31:0] mem_d_out = 32'hDEAD_BEEF;
  logic        mem_busy = 1'b1;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [4:0]  fifo_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bursts;
  logic [31:0] perf_stall;
  logic        busy_err;
`endif

  int checks = 0;
  int errors = 0;

  fetch_burst_master #(
    .ADDRESS_SIZE (32),
    .DATA_SIZE    (32),
    .FIFO_DEPTH   (16),
    .BURST_ACC    (2'b01),
    .START_ADDRESS(START)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_wren    (mem_wren),
    .mem_acc_size(mem_acc_size),
    .mem_d_out   (mem_d_out),
    .mem_busy    (mem_busy),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .fifo_count  (fifo_count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bursts (perf_bursts),
    .perf_stall  (perf_stall),
    .busy_err    (busy_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'h1000_0000 + ((a - START) >> 2);
  endfunction

  // Memory model: word k of a burst appears after the k-th edge following the
  // edge where mem_en rose (or the address changed); garbage when idle.
  initial begin : mem_model
    logic        prev_en;
    logic [31:0] prev_addr;
    int unsigned beat;
    prev_en   = 1'b0;
    prev_addr = '0;
    beat      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (!prev_en || mem_addr != prev_addr) beat = 0;
        else beat = beat + 1;
        mem_d_out = data_of(mem_addr + 32'(beat * 4));
      end else begin
        mem_d_out = 32'hDEAD_BEEF;
      end
      prev_en   = mem_en;
      prev_addr = mem_addr;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Hold ready high and check the next n delivered words are consecutive from first_pc.
  task automatic pop_expect(input int n, input logic [31:0] first_pc, input string tag);
    logic [31:0] exp_pc;
    int got;
    int budget;
    exp_pc     = first_pc;
    got        = 0;
    budget     = 0;
    inst_ready = 1'b1;
    while (got < n && budget < 400) begin
      if (inst_valid) begin
        chk({tag, " pc"}, inst_pc, exp_pc);
        chk({tag, " data"}, inst_data, data_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      step();
      budget++;
    end
    chk({tag, " delivered"}, 32'(got), 32'(n));
  endtask

  typedef struct {
    logic        ready;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int          budget;
    int          en_seen;
    int          max_cnt;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] s0;
`endif

    // Expected state after each edge following reset release, ready held high.
    vecs[0] = '{1'b1, 1'b1, START,         1'b0, 32'h0,         32'h0,         5'd0};
    vecs[1] = '{1'b1, 1'b1, START,         1'b1, 32'h8002_0000, 32'h1000_0000, 5'd1};
    vecs[2] = '{1'b1, 1'b1, START,         1'b1, 32'h8002_0004, 32'h1000_0001, 5'd1};
    vecs[3] = '{1'b1, 1'b1, START,         1'b1, 32'h8002_0008, 32'h1000_0002, 5'd1};
    vecs[4] = '{1'b1, 1'b0, START,         1'b1, 32'h8002_000C, 32'h1000_0003, 5'd1};
    vecs[5] = '{1'b1, 1'b0, START,         1'b0, 32'h0,         32'h0,         5'd0};
    vecs[6] = '{1'b1, 1'b1, 32'h8002_0010, 1'b0, 32'h0,         32'h0,         5'd0};
    vecs[7] = '{1'b1, 1'b1, 32'h8002_0010, 1'b1, 32'h8002_0010, 32'h1000_0004, 5'd1};

    // Reset values
    do_reset();
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst mem_addr", mem_addr, START);
    chk("rst mem_wren", 32'(mem_wren), 32'd0);
    chk("rst acc_size", 32'(mem_acc_size), 32'd1);
    chk("rst count", 32'(fifo_count), 32'd0);
    chk("rst valid", 32'(inst_valid), 32'd0);
    chk("rst inst_pc", inst_pc, 32'd0);
    chk("rst inst_data", inst_data, 32'd0);

    // Streaming fetch, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      inst_ready = vecs[i].ready;
      step();
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].en));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d valid", i), 32'(inst_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d count", i), 32'(fifo_count), 32'(vecs[i].cnt));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].pc);
        chk($sformatf("v%0d inst_data", i), inst_data, vecs[i].data);
      end
    end

    // Fill with ready low: exactly 16 words, then no further requests
    do_reset();
    repeat (40) step();
    chk("fill count", 32'(fifo_count), 32'd16);
    chk("fill mem_en", 32'(mem_en), 32'd0);
    chk("fill head pc", inst_pc, START);
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_en) en_seen++;
    end
    chk("fill no request", 32'(en_seen), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    s0 = perf_stall;
    repeat (5) step();
    chk("perf_stall step", perf_stall, s0 + 32'd5);
    chk("perf_bursts", perf_bursts, 32'd4);
    chk("busy_err", 32'(busy_err), 32'd0);
`endif

    // Pop down to 13: still too full for a 4-word burst
    inst_ready = 1'b1;
    repeat (3) step();
    inst_ready = 1'b0;
    chk("c13 count", 32'(fifo_count), 32'd13);
    en_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_en) en_seen++;
    end
    chk("c13 no request", 32'(en_seen), 32'd0);
    chk("c13 count hold", 32'(fifo_count), 32'd13);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("c12 count", 32'(fifo_count), 32'd12);
    step();
    chk("c12 mem_en", 32'(mem_en), 32'd1);
    chk("c12 mem_addr", mem_addr, 32'h8002_0040);
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    chk("c12 max count", 32'(max_cnt), 32'd16);
    chk("c12 final count", 32'(fifo_count), 32'd16);
    chk("c12 head pc", inst_pc, 32'h8002_0010);
    pop_expect(20, 32'h8002_0010, "drain");

    // Redirect during the third beat
    do_reset();
    inst_ready = 1'b1;
    repeat (3) step();
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0100;
    step();
    redirect = 1'b0;
    chk("rd valid", 32'(inst_valid), 32'd0);
    chk("rd count", 32'(fifo_count), 32'd0);
    chk("rd mem_en", 32'(mem_en), 32'd0);
    step();
    chk("rd gap mem_en", 32'(mem_en), 32'd0);
    step();
    chk("rd new mem_en", 32'(mem_en), 32'd1);
    chk("rd new mem_addr", mem_addr, 32'h8002_0100);
    pop_expect(5, 32'h8002_0100, "rd deliver");

    // Redirect together with a pop at count 5
    do_reset();
    budget = 0;
    while (fifo_count != 5'd5 && budget < 50) begin
      step();
      budget++;
    end
    chk("rp reach 5", 32'(fifo_count), 32'd5);
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0200;
    inst_ready  = 1'b1;
    step();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    chk("rp count", 32'(fifo_count), 32'd0);
    chk("rp valid", 32'(inst_valid), 32'd0);
    pop_expect(2, 32'h8002_0200, "rp deliver");

    // Asynchronous reset mid-burst
    do_reset();
    repeat (3) step();
    chk("mr in burst", 32'(mem_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr mem_en", 32'(mem_en), 32'd0);
    chk("mr count", 32'(fifo_count), 32'd0);
    chk("mr mem_addr", mem_addr, START);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("mr restart en", 32'(mem_en), 32'd1);
    chk("mr restart addr", mem_addr, START);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
